// File: rtl/transpose_rotate_ctrl_pkg.sv
// Shared constants, row-index type and controller state encoding for the
// row-rotation controller.
package transpose_pkg;

  localparam int N_ELEMS    = 16;
  localparam int ELEM_WIDTH = 32;
  localparam int ROW_WIDTH  = N_ELEMS * ELEM_WIDTH;
  localparam int IDX_W      = $clog2(N_ELEMS);

  typedef logic [IDX_W-1:0] row_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/transpose_rotate_ctrl_shift.sv
// Combinational barrel rotator: rotates a TOTAL_WIDTH vector by shift_amt_i
// bits, right when SHIFT_DIR is 0 and left otherwise.
module circular_shift #(
  parameter int TOTAL_WIDTH = 512,
  parameter int SHIFT_DIR   = 0,
  parameter int SHAMT_W     = $clog2(TOTAL_WIDTH)
) (
  input  logic [TOTAL_WIDTH-1:0] data_i,
  input  logic [SHAMT_W-1:0]     shift_amt_i,
  output logic [TOTAL_WIDTH-1:0] data_o
);

  // Doubling the word turns a rotate into a plain shift plus a window select.
  logic [2*TOTAL_WIDTH-1:0] doubled;

  assign doubled = {data_i, data_i};

  generate
    if (SHIFT_DIR == 0) begin : g_right
      assign data_o = TOTAL_WIDTH'(doubled >> shift_amt_i);
    end else begin : g_left
      assign data_o = TOTAL_WIDTH'((doubled << shift_amt_i) >> TOTAL_WIDTH);
    end
  endgenerate

endmodule

// File: rtl/transpose_rotate_ctrl.sv
// Matrix pass controller: accepts N_ELEMS rows per pass, rotates row k by
// (k*step mod N_ELEMS) elements and presents it through a one-deep
// registered output stage with valid/ready handshaking.
module transpose_rotate_ctrl
  import transpose_pkg::*;
#(
  parameter int N_ELEMS    = transpose_pkg::N_ELEMS,
  parameter int ELEM_WIDTH = transpose_pkg::ELEM_WIDTH,
  parameter int SHIFT_DIR  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(N_ELEMS)-1:0]      cfg_step,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_ELEMS*ELEM_WIDTH-1:0]   in_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_ELEMS*ELEM_WIDTH-1:0]   out_row,
  output logic [$clog2(N_ELEMS)-1:0]      out_idx,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  localparam int CNT_W   = $clog2(N_ELEMS);
  localparam int ROW_W   = N_ELEMS * ELEM_WIDTH;
  localparam int EW_LOG  = $clog2(ELEM_WIDTH);
  localparam int SHAMT_W = $clog2(ROW_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]   offset_q, offset_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [CNT_W-1:0]   out_idx_q, out_idx_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;

  logic               accept;
  logic               drain;
  logic               last_row;
  logic [CNT_W:0]     offset_sum;
  logic [SHAMT_W-1:0] shift_amt;
  logic [ROW_W-1:0]   rotated;

  assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid_q && out_ready;
  assign last_row   = (row_cnt_q == CNT_W'(N_ELEMS - 1));
  assign offset_sum = {1'b0, offset_q} + {1'b0, step_q};

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_row   = out_row_q;

  // Element offset to bit offset: a constant shift for power-of-two widths.
  generate
    if ((ELEM_WIDTH & (ELEM_WIDTH - 1)) == 0) begin : g_pow2
      assign shift_amt = SHAMT_W'(offset_q) << EW_LOG;
    end else begin : g_mult
      assign shift_amt = SHAMT_W'(offset_q) * SHAMT_W'(ELEM_WIDTH);
    end
  endgenerate

  circular_shift #(
    .TOTAL_WIDTH (ROW_W),
    .SHIFT_DIR   (SHIFT_DIR),
    .SHAMT_W     (SHAMT_W)
  ) u_shift (
    .data_i      (in_row),
    .shift_amt_i (shift_amt),
    .data_o      (rotated)
  );

  // Pass sequencing: start latch, per-row offset accumulation, done pulse.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    row_cnt_d = row_cnt_q;
    offset_d  = offset_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          step_d    = cfg_step;
          row_cnt_d = '0;
          offset_d  = '0;
        end
      end
      RUN: begin
        if (accept) begin
          row_cnt_d = row_cnt_q + 1'b1;
          // Both operands are below N_ELEMS, so one conditional subtract wraps.
          if (offset_sum >= (CNT_W+1)'(N_ELEMS)) begin
            offset_d = CNT_W'(offset_sum - (CNT_W+1)'(N_ELEMS));
          end else begin
            offset_d = offset_sum[CNT_W-1:0];
          end
          if (last_row) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain && out_last_q) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: load on accept, release on downstream take, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_row_d   = out_row_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_row_d   = rotated;
      out_idx_d   = row_cnt_q;
      out_last_d  = last_row;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      row_cnt_q <= '0;
      offset_q  <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      row_cnt_q <= row_cnt_d;
      offset_q  <= offset_d;
    end
  end

  // Output stage register (stage boundary between shifter and downstream).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_row_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_row_q   <= out_row_d;
    end
  end

endmodule

// File: tb/tb_transpose_rotate_ctrl.sv
// Bench for transpose_rotate_ctrl at N_ELEMS=4, ELEM_WIDTH=8, right rotation.
module tb_transpose_rotate_ctrl;

  localparam int N  = 4;
  localparam int EW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cfg_step;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_row;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_row;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [31:0] row;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   m_off, m_cnt, m_step;

  transpose_rotate_ctrl #(
    .N_ELEMS    (N),
    .ELEM_WIDTH (EW),
    .SHIFT_DIR  (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_step  (cfg_step),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Right rotation by k elements: output element i takes input element (i+k)%N.
  function automatic logic [31:0] rot_model(input logic [31:0] r, input int k);
    logic [31:0] o;
    for (int i = 0; i < N; i++) begin
      o[i*EW +: EW] = r[((i + k) % N)*EW +: EW];
    end
    return o;
  endfunction

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_output: got row %h idx %0d, required no output", out_row, out_idx);
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if (out_row !== e.row) begin
            n_fail++;
            $display("FAIL out_row: got %h, required %h", out_row, e.row);
          end
          n_cmp++;
          if (out_idx !== e.idx) begin
            n_fail++;
            $display("FAIL out_idx: got %0d, required %0d", out_idx, e.idx);
          end
          n_cmp++;
          if (out_last !== e.last) begin
            n_fail++;
            $display("FAIL out_last: got %b, required %b (idx %0d)", out_last, e.last, e.idx);
          end
          n_cmp++;
          if (done !== e.last) begin
            n_fail++;
            $display("FAIL done_pulse: got %b, required %b (idx %0d)", done, e.last, e.idx);
          end
        end
      end else if (done === 1'b1) begin
        n_cmp++; n_fail++;
        $display("FAIL stray_done: got done=1 without last-row handoff, required 0");
      end
    end
  endtask

  task automatic start_pass(input int step);
    start    = 1'b1;
    cfg_step = 2'(step);
    @(posedge clk); #1;
    start  = 1'b0;
    m_off  = 0;
    m_cnt  = 0;
    m_step = step;
  endtask

  task automatic send_row(input logic [31:0] r, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_row   = r;
    @(negedge clk);
    while (in_ready !== 1'b1 && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=%b after %0d cycles, required 1", in_ready, waits);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{row: rot_model(r, m_off), idx: 2'(m_cnt), last: (m_cnt == N - 1)});
      m_off = (m_off + m_step) % N;
      m_cnt++;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (done !== 1'b1 && c < 50);
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: got done=%b after %0d cycles, required 1", done, c);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_done: got %b, required 0", busy);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rows_outstanding: got %0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_step = '0; in_valid = 1'b0;
    in_row = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    n_cmp++; if (out_row !== 32'h0) begin n_fail++; $display("FAIL rst_out_row: got %h, required 0", out_row); end
    n_cmp++; if (out_idx !== 2'd0) begin n_fail++; $display("FAIL rst_out_idx: got %0d, required 0", out_idx); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_step1();
    int w;
    start_pass(1);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_run: got %b, required 1", busy); end
    for (int i = 0; i < N; i++) send_row(32'h44332211, w);
    wait_done();
  endtask

  task automatic test_step2();
    int w;
    start_pass(2);
    for (int i = 0; i < N; i++) send_row(32'hDDCCBBAA, w);
    wait_done();
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    start_pass(1);
    send_row(32'h04030201, w);
    in_valid = 1'b1;
    in_row   = 32'h14131211;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b, required 1", out_valid); end
      n_cmp++; if (out_row !== 32'h04030201) begin n_fail++; $display("FAIL stall_row: got %h, required 04030201", out_row); end
      n_cmp++; if (out_idx !== 2'd0) begin n_fail++; $display("FAIL stall_idx: got %0d, required 0", out_idx); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 1; i < N; i++) begin
      send_row(32'h04030201 + 32'(i) * 32'h10101010, w);
      n_cmp++;
      if (w != 0) begin n_fail++; $display("FAIL release_rate: got %0d wait cycles on row %0d, required 0", w, i); end
    end
    wait_done();
  endtask

  task automatic test_start_ignored();
    int w;
    start_pass(1);
    send_row(32'h0D0C0B0A, w);
    start    = 1'b1;
    cfg_step = 2'd3;
    send_row(32'h1D1C1B1A, w);
    start    = 1'b0;
    send_row(32'h2D2C2B2A, w);
    send_row(32'h3D3C3B3A, w);
    wait_done();
  endtask

  task automatic test_reset_midpass();
    int w;
    int d0;
    start_pass(1);
    send_row(32'h55667788, w);
    send_row(32'h99AABBCC, w);
    d0  = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_done: got %0d pulses, required %0d", done_cnt, d0); end
    sb.delete();
    @(posedge clk); #1;
    start_pass(1);
    send_row(32'hA1B2C3D4, w);
    for (int i = 1; i < N; i++) send_row(32'hA1B2C3D4 ^ 32'(i), w);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int w;
    start_pass(3);
    for (int i = 0; i < N; i++) send_row(32'h87654321 + 32'(i), w);
    wait_done();
    start_pass(1);
    send_row(32'hF4F3F2F1, w);
    n_cmp++;
    if (w != 0) begin n_fail++; $display("FAIL b2b_gap: got %0d wait cycles, required 0", w); end
    for (int i = 1; i < N; i++) send_row(32'hF4F3F2F1 - 32'(i), w);
    wait_done();
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_step1();
    test_step2();
    test_backpressure();
    test_start_ignored();
    test_reset_midpass();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/transpose_rotate_ctrl.md
TRANSPOSE_ROTATE_CTRL -- requirements
Module: transpose_rotate_ctrl

Interface
REQ-001 SHALL have parameter N_ELEMS, default 16: elements per row; number of rows per matrix.
REQ-002 SHALL have parameter ELEM_WIDTH, default 32: bits per element.
REQ-003 SHALL have parameter SHIFT_DIR, default 0: rotation direction (0 = right, 1 = left), passed to the shifter.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: begin one matrix pass; sampled only in IDLE.
REQ-007 SHALL have port cfg_step, input, $clog2(N_ELEMS): per-row rotation increment in elements; latched on accepted start.
REQ-008 SHALL have port in_valid, input, 1: in_row is valid.
REQ-009 SHALL have port in_ready, output, 1: the block accepts in_row this cycle.
REQ-010 SHALL have port in_row, input, N_ELEMS*ELEM_WIDTH: one matrix row, element 0 in the LSBs.
REQ-011 SHALL have port out_valid, output, 1: out_row is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts out_row.
REQ-013 SHALL have port out_row, output, N_ELEMS*ELEM_WIDTH: rotated row.
REQ-014 SHALL have port out_idx, output, $clog2(N_ELEMS): row index of out_row.
REQ-015 SHALL have port out_last, output, 1: out_row is row N_ELEMS-1.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when the last row leaves.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-019 SHALL move IDLE->RUN on start=1, latching cfg_step and clearing row_cnt and offset to 0.
REQ-020 SHALL ignore start in RUN and DRAIN, with no effect on the pass.
REQ-021 SHALL accept an input row only when in_valid && in_ready.
REQ-022 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-023 SHALL rotate each accepted row by offset*ELEM_WIDTH bits in direction SHIFT_DIR.
REQ-024 SHALL register the rotated row into out_row, with out_valid rising the cycle after acceptance (latency 1).
REQ-025 SHALL register out_idx = row_cnt and out_last = (row_cnt==N_ELEMS-1) with the row.
REQ-026 SHALL, on each accept, update offset <= (offset + step) mod N_ELEMS and row_cnt <= row_cnt+1 (wrap-free addition; no multiplier).
REQ-027 SHALL pass row 0 unrotated (offset 0), with out_row equal to in_row.
REQ-028 SHALL pass every row unchanged when step=0.
REQ-029 SHALL clear out_valid on out_valid && out_ready unless a new row is accepted in the same cycle; accept and drain in the same cycle SHALL sustain one row per cycle.
REQ-030 SHALL hold out_row, out_idx and out_last stable while out_valid && !out_ready.
REQ-031 SHALL move RUN->DRAIN on accepting row N_ELEMS-1.
REQ-032 SHALL move DRAIN->IDLE when out_last is accepted downstream, and pulse done in that same cycle.
REQ-033 SHALL permit start on the first IDLE cycle after done (back-to-back matrices).

Reset
REQ-034 SHALL, on rst=1 at a clock edge, enter IDLE and clear out_valid, out_last, out_idx, out_row, row_cnt, offset, step, busy and done to 0.
REQ-035 SHALL let rst take priority over all other inputs, including mid-pass; the partial matrix is discarded and no done is generated.

Structure
REQ-036 SHALL place N_ELEMS, ELEM_WIDTH, ROW_WIDTH, the row-index typedef and the FSM state enum in shared package transpose_pkg.
REQ-037 SHALL instantiate exactly one circular_shift sub-module with TOTAL_WIDTH=ROW_WIDTH and SHIFT_DIR passed through; shift_amt = offset*ELEM_WIDTH, computed as a constant-multiple left shift when ELEM_WIDTH is a power of two.

Verification (N_ELEMS=4, ELEM_WIDTH=8, SHIFT_DIR=0)
REQ-038 SHALL cover: start with step=1, rows 0x44332211 x4, out_ready=1 -> outputs 0x44332211, 0x11443322, 0x22114433, 0x33221144; idx 0..3; out_last on the 4th; done on the 4th acceptance.
REQ-039 SHALL cover: step=2, rows 0xDDCCBBAA -> offsets 0,2,0,2 -> outputs 0xDDCCBBAA, 0xBBAADDCC, 0xDDCCBBAA, 0xBBAADDCC.
REQ-040 SHALL cover: out_ready held 0 for 3 cycles after the first output -> out_row stable, in_ready=0 and no row lost; then one row per cycle on release.
REQ-041 SHALL cover: start pulsed during RUN with a different cfg_step -> ignored; outputs continue using the original step.
REQ-042 SHALL cover: rst asserted after 2 accepted rows -> the next cycle shows out_valid=0, busy=0 and no done; a new start produces row 0 unrotated.
REQ-043 SHALL cover: start asserted on the cycle after done -> the second matrix is accepted with no gap and idx restarts at 0.
